csr_snapshot_ctrl: RTL and testbench

// Sequences the read port of the metrics CSR file and shares it between the core and a snapshot engine.
// On a trigger (external pulse or periodic timer), the engine walks CSR addresses 0..NUM_CTRS-1.
// It streams each counter value out on a valid/ready port for a host or trace sink.

---
 rtl/csr_snapshot_ctrl.sv | 147 ++++++++++++++
 tb/tb_csr_snapshot_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_snapshot_ctrl.sv
// Snapshot sequencer for the metrics CSR read port: the core always wins the port,
// and the engine streams addresses 0..NUM_CTRS-1 out over a valid/ready interface.
module csr_snapshot_ctrl #(
    parameter int NUM_CTRS   = 4,
    parameter int PERIOD     = 0,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snap_req,
    input  logic                  core_rd_req,
    input  logic [3:0]            core_rd_addr,
    output logic [31:0]           core_rd_data,
    output logic [3:0]            csr_rd_addr,
    input  logic [31:0]           csr_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [3:0]            out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  snap_dropped,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CTRS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] idx;
    logic       trig_t;
    logic       trigger;
    logic       drop;
    logic       load_word;
    logic       accept;

    // Free-running period timer; it keeps counting while a snapshot is in flight.
    if (PERIOD > 0) begin : g_timer
        localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
        localparam logic [TW-1:0] TIMER_MAX = TW'(PERIOD - 1);
        logic [TW-1:0] timer;

        always_ff @(posedge clk) begin
            if (rst) begin
                timer <= '0;
            end else if (timer == TIMER_MAX) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end

        assign trig_t = (timer == TIMER_MAX);
    end else begin : g_no_timer
        assign trig_t = 1'b0;
    end

    assign trigger      = snap_req | trig_t;
    assign drop         = trigger && (state != IDLE);
    assign busy         = (state != IDLE);
    assign core_rd_data = csr_rd_data;

    always_comb begin
        csr_rd_addr = 4'd0;
        if (core_rd_req) begin
            csr_rd_addr = core_rd_addr;
        end else if (state == READ) begin
            csr_rd_addr = idx;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a latch.
    always_comb begin
        state_next = state;
        load_word  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (!core_rd_req) begin
                    load_word  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // out_valid is always high in WAIT, so ready alone completes the handshake.
                if (out_ready) begin
                    accept     = 1'b1;
                    state_next = out_last ? IDLE : READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= 4'd0;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_idx      <= 4'd0;
            out_last     <= 1'b0;
            snap_dropped <= 1'b0;
            drop_count   <= '0;
        end else begin
            if ((state == IDLE) && trigger) begin
                idx <= 4'd0;
            end else if (accept && !out_last) begin
                idx <= idx + 4'd1;
            end

            if (load_word) begin
                out_valid <= 1'b1;
                out_data  <= csr_rd_data;
                out_idx   <= idx;
                out_last  <= (idx == LAST_IDX);
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            snap_dropped <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_csr_snapshot_ctrl.sv
// Directed bench: dut_a (no timer) takes the linear step sequence; dut_b (PERIOD=20)
// free-runs from reset release and its trigger cycles are logged for a final check.
module tb_csr_snapshot_ctrl;

    localparam int NUM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // dut_a signals
    logic        rst = 1'b1;
    logic        snap_req = 1'b0;
    logic        core_rd_req = 1'b0;
    logic [3:0]  core_rd_addr = 4'd0;
    logic [31:0] core_rd_data;
    logic [3:0]  csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        snap_dropped;
    logic [7:0]  drop_count;

    // dut_b signals
    logic        rst_b = 1'b1;
    logic [31:0] core_rd_data_b;
    logic [3:0]  csr_rd_addr_b;
    logic [31:0] csr_rd_data_b;
    logic        out_valid_b;
    logic [31:0] out_data_b;
    logic [3:0]  out_idx_b;
    logic        out_last_b;
    logic        busy_b;
    logic        snap_dropped_b;
    logic [7:0]  drop_count_b;

    // CSR file model: counter at address a reads as 0xA0 + a.
    assign csr_rd_data   = 32'hA0 + {28'd0, csr_rd_addr};
    assign csr_rd_data_b = 32'hA0 + {28'd0, csr_rd_addr_b};

    csr_snapshot_ctrl #(.NUM_CTRS(NUM), .PERIOD(0), .DROP_CNT_W(8)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .snap_req     (snap_req),
        .core_rd_req  (core_rd_req),
        .core_rd_addr (core_rd_addr),
        .core_rd_data (core_rd_data),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_data  (csr_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy),
        .snap_dropped (snap_dropped),
        .drop_count   (drop_count)
    );

    csr_snapshot_ctrl #(.NUM_CTRS(NUM), .PERIOD(20), .DROP_CNT_W(8)) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .snap_req     (1'b0),
        .core_rd_req  (1'b0),
        .core_rd_addr (4'd0),
        .core_rd_data (core_rd_data_b),
        .csr_rd_addr  (csr_rd_addr_b),
        .csr_rd_data  (csr_rd_data_b),
        .out_valid    (out_valid_b),
        .out_ready    (1'b1),
        .out_data     (out_data_b),
        .out_idx      (out_idx_b),
        .out_last     (out_last_b),
        .busy         (busy_b),
        .snap_dropped (snap_dropped_b),
        .drop_count   (drop_count_b)
    );

    // dut_b monitor: cycle k after reset release is the one ending at the k-th posedge.
    int   pcount_b = 0;
    int   words_b  = 0;
    int   trig_log[$];
    logic busy_b_q = 1'b0;

    always @(posedge clk) begin
        if (rst_b) pcount_b <= 0;
        else       pcount_b <= pcount_b + 1;
    end

    always @(negedge clk) begin
        busy_b_q <= busy_b;
        if (!rst_b && busy_b && !busy_b_q && pcount_b <= 101) trig_log.push_back(pcount_b - 1);
        if (!rst_b && out_valid_b && pcount_b <= 110) words_b <= words_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entry: word first-1 is valid at this negedge with out_ready=1.
    task automatic drain(input string tag, input int first);
        for (int k = first; k < NUM; k++) begin
            @(negedge clk);
            @(negedge clk);
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_data"}, out_data, 32'hA0 + k);
            check({tag, "_idx"}, out_idx, k);
            check({tag, "_last"}, out_last, (k == NUM - 1));
        end
        @(negedge clk);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_dropped", snap_dropped, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_rd_addr", csr_rd_addr, 0);
        rst   = 1'b0;
        rst_b = 1'b0;

        // Basic snapshot, ready held high
        @(negedge clk);
        out_ready = 1'b1;
        snap_req  = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_valid0", out_valid, 0);
        for (int k = 0; k < NUM; k++) begin
            @(negedge clk);
            check("t1_valid", out_valid, 1);
            check("t1_data", out_data, 32'hA0 + k);
            check("t1_idx", out_idx, k);
            check("t1_last", out_last, (k == NUM - 1));
            @(negedge clk);
            if (k < NUM - 1) begin
                check("t1_gap_valid", out_valid, 0);
                check("t1_rd_addr", csr_rd_addr, k + 1);
            end else begin
                check("t1_busy_end", busy, 0);
            end
        end

        // Core read stall in READ
        snap_req = 1'b1;
        @(negedge clk);
        snap_req     = 1'b0;
        core_rd_req  = 1'b1;
        core_rd_addr = 4'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_core_data", core_rd_data, 32'hA2);
            check("t2_rd_addr", csr_rd_addr, 2);
            check("t2_no_word", out_valid, 0);
            @(negedge clk);
        end
        core_rd_req = 1'b0;
        check("t2_still_stalled", out_valid, 0);
        @(negedge clk);
        check("t2_resume_valid", out_valid, 1);
        check("t2_resume_data", out_data, 32'hA0);
        check("t2_resume_idx", out_idx, 0);
        drain("t2", 1);

        // Backpressure: ready low for 10 cycles on word 0
        out_ready = 1'b0;
        snap_req  = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_data", out_data, 32'hA0);
            check("t3_hold_idx", out_idx, 0);
            check("t3_hold_last", out_last, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain("t3", 1);

        // Dropped triggers while busy, plus one on the final handshake
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        @(negedge clk);
        check("t4_w0_data", out_data, 32'hA0);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check("t4_drop1_pulse", snap_dropped, 1);
        check("t4_drop1_count", drop_count, 1);
        @(negedge clk);
        check("t4_w1_data", out_data, 32'hA1);
        check("t4_w1_idx", out_idx, 1);
        check("t4_pulse_clear", snap_dropped, 0);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check("t4_drop2_pulse", snap_dropped, 1);
        check("t4_drop2_count", drop_count, 2);
        @(negedge clk);
        check("t4_w2_data", out_data, 32'hA2);
        @(negedge clk);
        @(negedge clk);
        check("t4_w3_data", out_data, 32'hA3);
        check("t4_w3_last", out_last, 1);
        check("t4_count_before", drop_count, 2);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check("t4_last_busy", busy, 0);
        check("t4_last_pulse", snap_dropped, 1);
        check("t4_last_count", drop_count, 3);
        @(negedge clk);
        check("t4_no_restart", busy, 0);
        check("t4_pulse_end", snap_dropped, 0);

        // Saturation: trigger held high while stuck in WAIT
        out_ready = 1'b0;
        snap_req  = 1'b1;
        repeat (300) @(negedge clk);
        check("t5_sat_count", drop_count, 32'hFF);
        check("t5_sat_pulse", snap_dropped, 1);
        check("t5_sat_valid", out_valid, 1);
        check("t5_sat_idx", out_idx, 0);
        check("t5_sat_data", out_data, 32'hA0);
        snap_req  = 1'b0;
        out_ready = 1'b1;
        drain("t5", 1);

        // Reset while WAIT with out_valid high
        out_ready = 1'b0;
        snap_req  = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        @(negedge clk);
        check("t6_pre_valid", out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_drop_count", drop_count, 0);
        check("t6_data", out_data, 0);
        out_ready = 1'b1;
        snap_req  = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check("t6_restart_busy", busy, 1);
        @(negedge clk);
        check("t6_restart_idx", out_idx, 0);
        check("t6_restart_data", out_data, 32'hA0);
        drain("t6", 1);

        // Periodic timer instance
        for (int i = 0; i < 200 && pcount_b < 112; i++) @(negedge clk);
        check("tb_timer_snapshots", trig_log.size(), 5);
        check("tb_timer_words", words_b, 20);
        for (int i = 0; i < 5 && i < trig_log.size(); i++) begin
            check("tb_timer_cycle", trig_log[i], 19 + 20 * i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
